iter_counter: RTL and testbench
===============================

Name: iter_counter

Overview:
- Parametrised iteration counter that sequences the shift-add multiplier and other multi-cycle datapath units.
- It replaces the fixed 32-step counter.
- Iteration count is programmable per operation, with a parameter default.
- Adds a stall enable, a last-iteration flag, a held done level with acknowledge, a one-cycle done pulse, and an auto-reload mode for back-to-back operations.

Parameters:
CNT_W, 6, width of Count and Term_In; must satisfy DEFAULT_TC <= 2^CNT_W-1
DEFAULT_TC, 32, terminal count used when Term_In = 0 at Load

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  synchronous active-low reset, sampled on Clk rising edge
Load  input  1  start/restart; captures Term_In and Auto_Reload
Term_In  input  CNT_W  iterations for this operation; 0 selects DEFAULT_TC
Auto_Reload  input  1  mode captured at Load: 1 = restart automatically at terminal count
Enable  input  1  advance count this cycle; 0 = stall/hold
Ack  input  1  clears K in DONE; in RUN, cancels auto-reload
Count  output  CNT_W  current iteration index, 0-based
Busy  output  1  high while in RUN
Iter_Last  output  1  combinational: Busy && (Count == Term_Reg-1)
K  output  1  done level, held until Ack or Load
Done_Pulse  output  1  one-cycle strobe on every terminal count

Behaviour:
- Interface: one clock (Clk); reset Rst_n is synchronous and active-low. It has priority over all inputs.
- Reset values: state IDLE, Count=0, Term_Reg=DEFAULT_TC, Reload_Reg=0, Busy=0, K=0, Done_Pulse=0, Iter_Last=0.
- States:
  - IDLE: no counting.
  - RUN: counting, Busy=1.
  - DONE: K=1.
- Load (any state, posedge):
  - Term_Reg <= (Term_In==0) ? DEFAULT_TC : Term_In.
  - Reload_Reg <= Auto_Reload.
  - Count <= 0, K <= 0, Busy <= 1, state <= RUN.
  - Load in RUN aborts the current operation and restarts; no Done_Pulse is emitted for the aborted run.
- RUN, Enable=1, not at terminal count (Count+1 != Term_Reg): Count <= Count+1.
- RUN, Enable=1, Count+1 == Term_Reg (terminal count):
  - Done_Pulse <= 1 for exactly one cycle.
  - If Reload_Reg=1: Count <= 0, stay in RUN, Busy stays 1, K stays 0.
  - If Reload_Reg=0: Count <= Term_Reg (holds final value), state <= DONE, Busy <= 0, K <= 1.
- RUN, Enable=0: all registers hold; Done_Pulse=0.
- Latency: with Enable held high, K rises at the Nth posedge after the Load posedge (N = effective terminal count). With N=32, Load at edge 0 gives K=1 after edge 32. Iter_Last is high during cycle N-1 (Count=N-1).
- Term_In=1: Iter_Last=1 immediately after Load; done after the first enabled edge.
- DONE:
  - Count and K hold.
  - Ack=1 -> state IDLE, K <= 0, Count <= 0.
  - Load -> RUN as above.
  - Load and Ack together: Load wins, K <= 0.
- Ack in RUN: Reload_Reg <= 0, so the run terminates into DONE at the next terminal count. Ack in IDLE is ignored.
- Ack and terminal count on the same edge in RUN with Reload_Reg=1: the reload still happens this edge (Count <= 0, Done_Pulse=1). Reload_Reg clears, and the next terminal count goes to DONE.
- Enable is ignored in IDLE and DONE.
- Count never exceeds Term_Reg and never wraps past 2^CNT_W-1.
- Rst_n low mid-RUN: next edge returns to reset values; no Done_Pulse.

Test Plan:
1. Reset, then Load with Term_In=0 and Enable=1 held -> Count steps 0..31. Iter_Last is high only at Count=31. K=1 and a single Done_Pulse after the 32nd edge; Busy falls on the same edge. K stays 1 until Ack; Ack -> IDLE, K=0, Count=0.
2. Load with Term_In=5, Enable toggled 1,0,1,0,... -> Count advances only on enabled edges. K rises after the 5th enabled edge (9 edges after Load); Count holds at 5 in DONE.
3. Auto_Reload=1, Term_In=4, Enable=1 -> Done_Pulse every 4th edge, Count 0,1,2,3,0,..., K stays 0. Ack asserted mid-sequence -> exactly one more terminal count, then DONE with K=1.
4. Load at Count=10 of a Term_In=20 run -> Count restarts at 0, no Done_Pulse; K after 20 further edges. In DONE, Load and Ack together -> RUN, K=0, Busy=1.
5. Term_In=1 -> Iter_Last=1 right after Load; K=1 after one enabled edge. Rst_n=0 for one edge mid-run in a separate run -> all outputs return to reset values, Term_Reg=DEFAULT_TC.
6. CNT_W=4, DEFAULT_TC=15, Term_In=15 -> Count reaches 15 without wrap; K=1 with Count=15.

Source files
------------

// File: rtl/iter_counter_if.sv
// Handshake bundle for iter_counter: control inputs from the sequencing
// datapath and the counter's status outputs, with modports for each side.
interface iter_counter_if #(
  parameter int CNT_W = 6
);
  logic             Load;
  logic [CNT_W-1:0] Term_In;
  logic             Auto_Reload;
  logic             Enable;
  logic             Ack;
  logic [CNT_W-1:0] Count;
  logic             Busy;
  logic             Iter_Last;
  logic             K;
  logic             Done_Pulse;

  // The sequencer that drives the counter.
  modport master (
    output Load, Term_In, Auto_Reload, Enable, Ack,
    input  Count, Busy, Iter_Last, K, Done_Pulse
  );

  // The counter itself.
  modport slave (
    input  Load, Term_In, Auto_Reload, Enable, Ack,
    output Count, Busy, Iter_Last, K, Done_Pulse
  );
endinterface

// File: rtl/iter_counter.sv
// Programmable iteration counter for multi-cycle datapath units such as the
// shift-add multiplier. Counts 0..N-1 per operation (N taken from Term_In at
// Load, or DEFAULT_TC when Term_In is zero), supports stalls, signals the
// last iteration, and either finishes into a held done level or reloads
// itself for back-to-back operations.
module iter_counter #(
  parameter int CNT_W      = 6,
  parameter int DEFAULT_TC = 32
) (
  input logic         Clk,
  input logic         Rst_n,
  iter_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEF_TC = CNT_W'(DEFAULT_TC);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] term_reg;
  logic             reload_reg;
  logic             busy;
  logic             k;
  logic             done_pulse;

  // One extra bit so the increment compare can never alias on wrap.
  logic [CNT_W:0]   count_inc;
  logic             at_terminal;

  // Next-count value and terminal-count detection for the RUN state.
  always_comb begin
    count_inc   = {1'b0, count} + 1'b1;
    at_terminal = (count_inc == {1'b0, term_reg});
  end

  // Single state machine holding all counter state and registered outputs.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state      <= IDLE;
      count      <= '0;
      term_reg   <= DEF_TC;
      reload_reg <= 1'b0;
      busy       <= 1'b0;
      k          <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (bus.Load) begin
        // Load restarts from any state; an aborted run emits no pulse.
        term_reg   <= (bus.Term_In == '0) ? DEF_TC : bus.Term_In;
        reload_reg <= bus.Auto_Reload;
        count      <= '0;
        k          <= 1'b0;
        busy       <= 1'b1;
        state      <= RUN;
      end else begin
        case (state)
          RUN: begin
            // Ack here only cancels auto-reload; a reload due on this
            // same edge still happens because the old reload_reg is used.
            if (bus.Ack) begin
              reload_reg <= 1'b0;
            end
            if (bus.Enable) begin
              if (at_terminal) begin
                done_pulse <= 1'b1;
                if (reload_reg) begin
                  count <= '0;
                end else begin
                  count <= term_reg;
                  busy  <= 1'b0;
                  k     <= 1'b1;
                  state <= DONE;
                end
              end else begin
                count <= count_inc[CNT_W-1:0];
              end
            end
          end
          DONE: begin
            if (bus.Ack) begin
              k     <= 1'b0;
              count <= '0;
              state <= IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.Count      = count;
  assign bus.Busy       = busy;
  assign bus.K          = k;
  assign bus.Done_Pulse = done_pulse;
  // term_reg is never zero, so term_reg-1 is always a valid index.
  assign bus.Iter_Last  = busy && (count == (term_reg - 1'b1));

endmodule

// File: tb/tb_iter_counter.sv
// Scoreboard bench for iter_counter: the stimulus process pushes the expected
// post-edge outputs for every cycle it drives, and a separate monitor pops and
// compares one entry after each rising edge. dut_a uses the default 6-bit
// configuration, dut_b a 4-bit counter with DEFAULT_TC=15.
module tb_iter_counter;

  logic Clk;
  logic Rst_n;

  iter_counter_if #(.CNT_W(6)) bus_a ();
  iter_counter_if #(.CNT_W(4)) bus_b ();

  iter_counter #(.CNT_W(6), .DEFAULT_TC(32)) dut_a (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus_a)
  );

  iter_counter #(.CNT_W(4), .DEFAULT_TC(15)) dut_b (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus_b)
  );

  typedef struct {
    string      nm;
    bit         sel;
    logic [9:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Flag encoding {Busy, Iter_Last, K, Done_Pulse}
  localparam logic [3:0] F_IDLE = 4'b0000;
  localparam logic [3:0] F_RUN  = 4'b1000;
  localparam logic [3:0] F_LAST = 4'b1100;
  localparam logic [3:0] F_DONE = 4'b0011;
  localparam logic [3:0] F_HOLD = 4'b0010;
  localparam logic [3:0] F_RLD  = 4'b1001;

  // Free-running clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Compare one scoreboard entry against the selected DUT.
  task automatic checkOutput(input exp_t e);
    logic [9:0] act;
    if (e.sel)
      act = {2'b00, bus_b.Count, bus_b.Busy, bus_b.Iter_Last, bus_b.K, bus_b.Done_Pulse};
    else
      act = {bus_a.Count, bus_a.Busy, bus_a.Iter_Last, bus_a.K, bus_a.Done_Pulse};
    checks++;
    if (act !== e.exp) begin
      errors++;
      $display("[TB] FAIL %s: got Count=%0d {B,L,K,P}=%b, expected Count=%0d {B,L,K,P}=%b",
               e.nm, act[9:4], act[3:0], e.exp[9:4], e.exp[3:0]);
    end
  endtask

  // Monitor: one expected entry per driven cycle, sampled after the edge.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (sb_q.size() > 0) checkOutput(sb_q.pop_front());
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic applyStimulus(input string nm, input bit sel, input bit rn,
                               input bit ld, input logic [5:0] ti, input bit ar,
                               input bit en, input bit ack,
                               input logic [5:0] e_cnt, input logic [3:0] e_flg);
    exp_t e;
    @(negedge Clk);
    Rst_n             = rn;
    bus_a.Load        = sel ? 1'b0 : ld;
    bus_a.Term_In     = ti;
    bus_a.Auto_Reload = sel ? 1'b0 : ar;
    bus_a.Enable      = sel ? 1'b0 : en;
    bus_a.Ack         = sel ? 1'b0 : ack;
    bus_b.Load        = sel ? ld : 1'b0;
    bus_b.Term_In     = ti[3:0];
    bus_b.Auto_Reload = sel ? ar : 1'b0;
    bus_b.Enable      = sel ? en : 1'b0;
    bus_b.Ack         = sel ? ack : 1'b0;
    e.nm  = nm;
    e.sel = sel;
    e.exp = {e_cnt, e_flg};
    sb_q.push_back(e);
  endtask

  // Shorthand for a cycle on dut_a with reset released.
  task automatic stepA(input string nm, input bit ld, input logic [5:0] ti,
                       input bit ar, input bit en, input bit ack,
                       input logic [5:0] e_cnt, input logic [3:0] e_flg);
    applyStimulus(nm, 1'b0, 1'b1, ld, ti, ar, en, ack, e_cnt, e_flg);
  endtask

  // Shorthand for a cycle on dut_b with reset released.
  task automatic stepB(input string nm, input bit ld, input logic [5:0] ti,
                       input bit en, input logic [5:0] e_cnt, input logic [3:0] e_flg);
    applyStimulus(nm, 1'b1, 1'b1, ld, ti, 1'b0, en, 1'b0, e_cnt, e_flg);
  endtask

  // Directed test sequence.
  initial begin
    Rst_n = 1'b0;
    bus_a.Load = 1'b0; bus_a.Term_In = '0; bus_a.Auto_Reload = 1'b0;
    bus_a.Enable = 1'b0; bus_a.Ack = 1'b0;
    bus_b.Load = 1'b0; bus_b.Term_In = '0; bus_b.Auto_Reload = 1'b0;
    bus_b.Enable = 1'b0; bus_b.Ack = 1'b0;

    // Reset state
    applyStimulus("reset0", 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 6'd0, F_IDLE);
    applyStimulus("reset1", 1'b0, 1'b0, 1'b1, 6'd5, 1'b1, 1'b1, 1'b1, 6'd0, F_IDLE);

    // 1: default terminal count of 32
    stepA("t1_load", 1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 6'd0, F_RUN);
    for (int i = 1; i <= 31; i++)
      stepA($sformatf("t1_cnt%0d", i), 1'b0, 6'd0, 1'b0, 1'b1, 1'b0,
            6'(i), (i == 31) ? F_LAST : F_RUN);
    stepA("t1_done", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 6'd32, F_DONE);
    stepA("t1_hold", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 6'd32, F_HOLD);
    stepA("t1_ack", 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 6'd0, F_IDLE);
    stepA("t1_ack_idle", 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 6'd0, F_IDLE);

    // 2: Term_In=5 with Enable toggling 1,0,1,0,...
    stepA("t2_load", 1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 6'd0, F_RUN);
    for (int j = 1; j <= 8; j++)
      stepA($sformatf("t2_edge%0d", j), 1'b0, 6'd0, 1'b0, 1'(j % 2), 1'b0,
            6'((j + 1) / 2), (((j + 1) / 2) == 4) ? F_LAST : F_RUN);
    stepA("t2_done", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 6'd5, F_DONE);
    stepA("t2_hold", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd5, F_HOLD);
    stepA("t2_en_ignored", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 6'd5, F_HOLD);
    stepA("t2_ack", 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 6'd0, F_IDLE);

    // 3: auto-reload Term_In=4, Ack mid-sequence
    stepA("t3_load", 1'b1, 6'd4, 1'b1, 1'b1, 1'b0, 6'd0, F_RUN);
    for (int r = 0; r < 2; r++) begin
      for (int i = 1; i <= 3; i++)
        stepA($sformatf("t3_r%0d_cnt%0d", r, i), 1'b0, 6'd0, 1'b0, 1'b1, 1'b0,
              6'(i), (i == 3) ? F_LAST : F_RUN);
      stepA($sformatf("t3_r%0d_reload", r), 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 6'd0, F_RLD);
    end
    stepA("t3_ack_mid", 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 6'd1, F_RUN);
    stepA("t3_cnt2", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 6'd2, F_RUN);
    stepA("t3_cnt3", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 6'd3, F_LAST);
    stepA("t3_done", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 6'd4, F_DONE);
    stepA("t3_hold", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 6'd4, F_HOLD);

    // 3b: Ack on the same edge as a reloading terminal count
    stepA("t3b_load", 1'b1, 6'd4, 1'b1, 1'b1, 1'b0, 6'd0, F_RUN);
    for (int i = 1; i <= 3; i++)
      stepA($sformatf("t3b_cnt%0d", i), 1'b0, 6'd0, 1'b0, 1'b1, 1'b0,
            6'(i), (i == 3) ? F_LAST : F_RUN);
    stepA("t3b_ack_tc", 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 6'd0, F_RLD);
    for (int i = 1; i <= 3; i++)
      stepA($sformatf("t3b_cnt%0d_b", i), 1'b0, 6'd0, 1'b0, 1'b1, 1'b0,
            6'(i), (i == 3) ? F_LAST : F_RUN);
    stepA("t3b_done", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 6'd4, F_DONE);

    // 4: restart at Count=10 of a 20-iteration run
    stepA("t4_load", 1'b1, 6'd20, 1'b0, 1'b1, 1'b0, 6'd0, F_RUN);
    for (int i = 1; i <= 10; i++)
      stepA($sformatf("t4_pre%0d", i), 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 6'(i), F_RUN);
    stepA("t4_reload", 1'b1, 6'd20, 1'b0, 1'b1, 1'b0, 6'd0, F_RUN);
    for (int i = 1; i <= 19; i++)
      stepA($sformatf("t4_cnt%0d", i), 1'b0, 6'd0, 1'b0, 1'b1, 1'b0,
            6'(i), (i == 19) ? F_LAST : F_RUN);
    stepA("t4_done", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 6'd20, F_DONE);
    stepA("t4_load_ack", 1'b1, 6'd20, 1'b0, 1'b1, 1'b1, 6'd0, F_RUN);
    stepA("t4_ack_run", 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 6'd1, F_RUN);

    // 5: Term_In=1, then reset in the middle of a run
    stepA("t5_load1", 1'b1, 6'd1, 1'b0, 1'b0, 1'b0, 6'd0, F_LAST);
    stepA("t5_stall", 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 6'd0, F_LAST);
    stepA("t5_done", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 6'd1, F_DONE);
    stepA("t5_load7", 1'b1, 6'd7, 1'b1, 1'b1, 1'b0, 6'd0, F_RUN);
    for (int i = 1; i <= 3; i++)
      stepA($sformatf("t5_cnt%0d", i), 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 6'(i), F_RUN);
    applyStimulus("t5_rst", 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 6'd0, F_IDLE);
    stepA("t5_post_rst", 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 6'd0, F_IDLE);

    // 6: 4-bit counter reaches 15 without wrapping
    stepB("t6_load15", 1'b1, 6'd15, 1'b1, 6'd0, F_RUN);
    for (int i = 1; i <= 14; i++)
      stepB($sformatf("t6_cnt%0d", i), 1'b0, 6'd0, 1'b1,
            6'(i), (i == 14) ? F_LAST : F_RUN);
    stepB("t6_done", 1'b0, 6'd0, 1'b1, 6'd15, F_DONE);
    stepB("t6_hold", 1'b0, 6'd0, 1'b1, 6'd15, F_HOLD);
    stepB("t6_load_def", 1'b1, 6'd0, 1'b1, 6'd0, F_RUN);
    for (int i = 1; i <= 14; i++)
      stepB($sformatf("t6_def%0d", i), 1'b0, 6'd0, 1'b1,
            6'(i), (i == 14) ? F_LAST : F_RUN);
    stepB("t6_def_done", 1'b0, 6'd0, 1'b1, 6'd15, F_DONE);

    // Drain the scoreboard within a bounded number of cycles.
    repeat (3) @(posedge Clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: got %0d entries left, expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
